// File: rtl/meteor_mover.sv
// meteor_mover: advances one meteor's screen position once per video frame and respawns it at the top.
// Latency: an accepted frame strobe updates MetY on the next edge; a respawn shows new coordinates 2 edges after its trigger.
// Backpressure: none; extra strobes inside the lockout window and all strobes while enable=0 are dropped.
module meteor_mover #(
  parameter int          TOP      = 0,
  parameter int          BOTTOM   = 480,
  parameter int          XMIN     = 64,
  parameter int          MAX_STEP = 32,
  parameter int          LOCKOUT  = 1024,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic [15:0] speed,
  input  logic        enable,
  input  logic        collide,
  output logic [15:0] MetX,
  output logic [15:0] MetY,
  output logic        active,
  output logic        dodged
);

  localparam int CW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FALL    = 2'd1,
    RESPAWN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   lfsr;
  logic [CW-1:0] lock_cnt;
  logic [15:0]   x_nxt, y_nxt;
  logic          active_nxt, dodged_nxt;
  logic          accept;
  logic [5:0]    step;
  logic [16:0]   sum;

  // A strobe counts only while falling, running, and outside the lockout window.
  assign accept = frame && (lock_cnt == '0) && enable && (state == FALL);
  assign step   = (speed > 16'(MAX_STEP)) ? 6'(MAX_STEP) : speed[5:0];
  assign sum    = {1'b0, MetY} + {11'd0, step};

  // Free-running Fibonacci LFSR (taps 16,14,13,11), right-shifting form; a non-zero seed never reaches zero.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Lockout counter: loaded on acceptance, then counts down to zero in every state.
  always_ff @(posedge clk) begin
    if (rst)                 lock_cnt <= '0;
    else if (accept)         lock_cnt <= CW'(LOCKOUT - 1);
    else if (lock_cnt != '0) lock_cnt <= lock_cnt - CW'(1);
  end

  // Next-state and next-output logic; everything holds unless a transition says otherwise.
  always_comb begin
    state_nxt  = state;
    x_nxt      = MetX;
    y_nxt      = MetY;
    active_nxt = active;
    dodged_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RESPAWN;
      end
      RESPAWN: begin
        x_nxt      = 16'(XMIN) + {7'd0, lfsr[8:0]};
        y_nxt      = 16'(TOP);
        active_nxt = 1'b1;
        state_nxt  = FALL;
      end
      FALL: begin
        // Collide wins over a same-cycle frame; enable=0 freezes everything, collide included.
        if (enable && collide) begin
          active_nxt = 1'b0;
          state_nxt  = RESPAWN;
        end else if (accept) begin
          if (sum >= 17'(BOTTOM)) begin
            dodged_nxt = 1'b1;
            active_nxt = 1'b0;
            state_nxt  = RESPAWN;
          end else begin
            y_nxt = sum[15:0];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and coordinate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      MetX   <= 16'(XMIN);
      MetY   <= 16'(TOP);
      active <= 1'b0;
      dodged <= 1'b0;
    end else begin
      state  <= state_nxt;
      MetX   <= x_nxt;
      MetY   <= y_nxt;
      active <= active_nxt;
      dodged <= dodged_nxt;
    end
  end

endmodule
